// File: rtl/data_interleaver.sv
// ============================================================================
//  Module      : data_interleaver
//  Description : 802.11a OFDM block interleaver, double-buffered, A/B pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_interleaver #(
    parameter int MAX_NCBPS = 288
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] rate,
    input  logic       A_in,
    input  logic       B_in,
    input  logic       AB_in_valid,
    output logic       A_out,
    output logic       B_out,
    output logic       AB_out_valid
);

    localparam int c_AW = $clog2(MAX_NCBPS);
    localparam int c_CW = $clog2(MAX_NCBPS / 2);

    localparam logic [1:0] c_MODE_48  = 2'd0;
    localparam logic [1:0] c_MODE_96  = 2'd1;
    localparam logic [1:0] c_MODE_192 = 2'd2;
    localparam logic [1:0] c_MODE_288 = 2'd3;

    function automatic logic [1:0] decode_rate(input logic [3:0] rc);
        logic [1:0] m;
        m = c_MODE_48;
        case (rc)
            4'b1101, 4'b1111: m = c_MODE_48;
            4'b0101, 4'b0111: m = c_MODE_96;
            4'b1001, 4'b1011: m = c_MODE_192;
            4'b0001, 4'b0011: m = c_MODE_288;
            default:          m = c_MODE_48;
        endcase
        return m;
    endfunction

    function automatic logic [c_CW-1:0] last_pair(input logic [1:0] mode);
        logic [c_CW-1:0] n;
        n = c_CW'(23);
        case (mode)
            c_MODE_48:  n = c_CW'(23);
            c_MODE_96:  n = c_CW'(47);
            c_MODE_192: n = c_CW'(95);
            c_MODE_288: n = c_CW'(143);
            default:    n = c_CW'(23);
        endcase
        return n;
    endfunction

    // With r = k mod 16, f = floor(k/16): i = (NCBPS/16)*r + f and
    // floor(16*i/NCBPS) reduces to r, so the second step only needs i mod s.
    function automatic logic [c_AW-1:0] perm_addr(input logic [c_AW-1:0] k,
                                                  input logic [1:0]      mode);
        logic [3:0]      r;
        logic [c_AW-5:0] f;
        logic [c_AW-1:0] i;
        logic [c_AW-1:0] j;
        logic [1:0]      f3;
        logic [1:0]      r3;
        logic [1:0]      d3;
        r  = k[3:0];
        f  = k[c_AW-1:4];
        f3 = 2'(f % (c_AW-4)'(3));
        r3 = 2'(r % 4'd3);
        d3 = (f3 >= r3) ? (f3 - r3) : (f3 + 2'd3 - r3);
        i  = c_AW'(r) * c_AW'(3) + c_AW'(f);
        j  = i;
        case (mode)
            c_MODE_48: begin
                i = c_AW'(r) * c_AW'(3) + c_AW'(f);
                j = i;
            end
            c_MODE_96: begin
                i = c_AW'(r) * c_AW'(6) + c_AW'(f);
                j = i;
            end
            c_MODE_192: begin
                i = c_AW'(r) * c_AW'(12) + c_AW'(f);
                j = {i[c_AW-1:1], f[0] ^ r[0]};
            end
            c_MODE_288: begin
                i = c_AW'(r) * c_AW'(18) + c_AW'(f);
                j = i - c_AW'(f3) + c_AW'(d3);
            end
            default: j = i;
        endcase
        return j;
    endfunction

    logic [MAX_NCBPS-1:0] r_bank [2];
    logic [1:0]           r_bank_mode [2];
    logic [1:0]           r_full;
    logic [1:0]           r_wmode;
    logic [c_CW-1:0]      r_wcnt;
    logic                 r_wsel;
    logic [c_CW-1:0]      r_rcnt;
    logic                 r_rsel;

    logic [1:0]           w_mode_cur;
    logic                 w_wr_en;
    logic                 w_wr_last;
    logic [c_AW-1:0]      w_k0;
    logic [c_AW-1:0]      w_k1;
    logic [c_AW-1:0]      w_j0;
    logic [c_AW-1:0]      w_j1;
    logic                 w_rd_en;
    logic                 w_rd_last;
    logic [c_AW-1:0]      w_ra0;
    logic [c_AW-1:0]      w_ra1;
    logic [1:0]           w_full_next;

    // The rate is only honoured on the first pair of a symbol.
    assign w_mode_cur = (r_wcnt == '0) ? decode_rate(rate) : r_wmode;
    assign w_wr_en    = AB_in_valid & ~r_full[r_wsel];
    assign w_wr_last  = (r_wcnt == last_pair(w_mode_cur));
    assign w_k0       = c_AW'({r_wcnt, 1'b0});
    assign w_k1       = c_AW'({r_wcnt, 1'b1});
    assign w_j0       = perm_addr(w_k0, w_mode_cur);
    assign w_j1       = perm_addr(w_k1, w_mode_cur);

    assign w_rd_en    = r_full[r_rsel];
    assign w_rd_last  = (r_rcnt == last_pair(r_bank_mode[r_rsel]));
    assign w_ra0      = c_AW'({r_rcnt, 1'b0});
    assign w_ra1      = c_AW'({r_rcnt, 1'b1});

    always_comb begin
        w_full_next = r_full;
        if (w_rd_en && w_rd_last) begin
            w_full_next[r_rsel] = 1'b0;
        end
        if (w_wr_en && w_wr_last) begin
            w_full_next[r_wsel] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_bank[r_wsel][w_j0] <= A_in;
            r_bank[r_wsel][w_j1] <= B_in;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_full         <= 2'b00;
            r_wmode        <= c_MODE_48;
            r_wcnt         <= '0;
            r_wsel         <= 1'b0;
            r_rcnt         <= '0;
            r_rsel         <= 1'b0;
            r_bank_mode[0] <= c_MODE_48;
            r_bank_mode[1] <= c_MODE_48;
            A_out          <= 1'b0;
            B_out          <= 1'b0;
            AB_out_valid   <= 1'b0;
        end else begin
            r_full <= w_full_next;

            if (w_wr_en) begin
                r_wmode <= w_mode_cur;
                if (w_wr_last) begin
                    r_wcnt              <= '0;
                    r_wsel              <= ~r_wsel;
                    r_bank_mode[r_wsel] <= w_mode_cur;
                end else begin
                    r_wcnt <= r_wcnt + c_CW'(1);
                end
            end

            // An idle reader emits pair 0 on the same edge it sees a full
            // bank, which keeps back-to-back symbols gap-free.
            if (w_rd_en) begin
                A_out        <= r_bank[r_rsel][w_ra0];
                B_out        <= r_bank[r_rsel][w_ra1];
                AB_out_valid <= 1'b1;
                if (w_rd_last) begin
                    r_rcnt <= '0;
                    r_rsel <= ~r_rsel;
                end else begin
                    r_rcnt <= r_rcnt + c_CW'(1);
                end
            end else begin
                A_out        <= 1'b0;
                B_out        <= 1'b0;
                AB_out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_interleaver.sv
// ============================================================================
//  Module      : tb_data_interleaver
//  Description : Directed self-checking bench for data_interleaver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_interleaver;

    logic       Clk = 1'b0;
    logic       reset;
    logic [3:0] rate;
    logic       A_in;
    logic       B_in;
    logic       AB_in_valid;
    logic       A_out;
    logic       B_out;
    logic       AB_out_valid;

    data_interleaver #(.MAX_NCBPS(288)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .rate         (rate),
        .A_in         (A_in),
        .B_in         (B_in),
        .AB_in_valid  (AB_in_valid),
        .A_out        (A_out),
        .B_out        (B_out),
        .AB_out_valid (AB_out_valid)
    );

    always #5 Clk = ~Clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         idle_dirty = 0;
    int         first_in_cyc = 0;
    logic [1:0] out_q[$];
    int         out_cyc[$];
    bit         sym_bits [0:863];
    bit         exp_bits [0:863];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (AB_out_valid) begin
            out_q.push_back({A_out, B_out});
            out_cyc.push_back(cyc);
        end else if (A_out || B_out) begin
            idle_dirty++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference permutation written straight from the 802.11a formula.
    function automatic int perm(input int k, input int ncbps, input int s);
        int i;
        i = (ncbps / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
    endfunction

    function automatic int out_bit(input int p, input int which);
        if (p >= out_q.size()) return -1;
        return (which == 0) ? int'(out_q[p][1]) : int'(out_q[p][0]);
    endfunction

    function automatic int ones_out();
        int n = 0;
        foreach (out_q[p]) n += int'(out_q[p][1]) + int'(out_q[p][0]);
        return n;
    endfunction

    task automatic drive(input logic a, input logic b, input logic v, input logic [3:0] rc);
        @(negedge Clk);
        A_in        = a;
        B_in        = b;
        AB_in_valid = v;
        rate        = rc;
    endtask

    task automatic send_pairs(input int first, input int count, input logic [3:0] rc,
                              input bit gapped);
        logic [3:0] r;
        for (int p = first; p < first + count; p++) begin
            r = (gapped && p > first) ? 4'b0011 : rc;
            if (gapped) begin
                int g = $urandom_range(0, 2);
                for (int x = 0; x < g; x++) drive(1'($urandom), 1'($urandom), 1'b0, r);
            end
            drive(sym_bits[2*p], sym_bits[2*p+1], 1'b1, r);
            if (p == first) first_in_cyc = cyc;
        end
    endtask

    task automatic wait_outputs(input int n, input string tag);
        int budget = 0;
        while (out_q.size() < n && budget < 2000) begin
            @(negedge Clk);
            budget++;
        end
        repeat (5) @(negedge Clk);
        check({tag, " pairs"}, out_q.size(), n);
    endtask

    task automatic check_symbols(input int ncbps, input int s, input int nsym, input string tag);
        int mism = 0;
        for (int t = 0; t < nsym; t++)
            for (int k = 0; k < ncbps; k++)
                exp_bits[t*ncbps + perm(k, ncbps, s)] = sym_bits[t*ncbps + k];
        for (int p = 0; p < out_q.size() && p < nsym*ncbps/2; p++)
            if (out_q[p] !== {logic'(exp_bits[2*p]), logic'(exp_bits[2*p+1])}) mism++;
        check({tag, " data"}, mism, 0);
    endtask

    task automatic clear_bits();
        for (int i = 0; i < 864; i++) sym_bits[i] = 1'b0;
    endtask

    task automatic random_bits();
        for (int i = 0; i < 864; i++) sym_bits[i] = 1'($urandom);
    endtask

    task automatic flush();
        out_q.delete();
        out_cyc.delete();
    endtask

    initial begin
        int span;
        reset       = 1'b0;
        rate        = 4'b1001;
        A_in        = 1'b0;
        B_in        = 1'b0;
        AB_in_valid = 1'b0;

        repeat (2) drive(1'($urandom), 1'($urandom), 1'($urandom), 4'b1001);
        @(posedge Clk);
        #1;
        check("rst valid", AB_out_valid, 0);
        check("rst A_out", A_out, 0);
        check("rst B_out", B_out, 0);
        @(negedge Clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b1001);
        flush();

        // 24 Mbps, single one at k=3, with an idle cycle before the last pair
        clear_bits();
        sym_bits[3] = 1'b1;
        send_pairs(0, 95, 4'b1001, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b1001);
        check("early out", out_q.size(), 0);
        send_pairs(95, 1, 4'b1001, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b1001);
        wait_outputs(96, "r24a");
        check("r24a k3 B pair18", out_bit(18, 1), 1);
        check("r24a ones", ones_out(), 1);
        check_symbols(192, 2, 1, "r24a");
        flush();

        // k=2 -> j=24 (A of pair 12); k=17 -> i=13 -> j=12 (A of pair 6)
        clear_bits();
        sym_bits[2]  = 1'b1;
        sym_bits[17] = 1'b1;
        send_pairs(0, 96, 4'b1001, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b1001);
        wait_outputs(96, "r24b");
        check("r24b k2 A pair12", out_bit(12, 0), 1);
        check("r24b k17 A pair6", out_bit(6, 0), 1);
        check("r24b ones", ones_out(), 2);
        flush();

        // 6 Mbps, k=1 -> j=3
        clear_bits();
        sym_bits[1] = 1'b1;
        send_pairs(0, 24, 4'b1101, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b1101);
        wait_outputs(24, "r6");
        check("r6 k1 B pair1", out_bit(1, 1), 1);
        check("r6 ones", ones_out(), 1);
        check_symbols(48, 1, 1, "r6");
        flush();

        // 54 Mbps, k=1 -> j=20, k=3 -> j=54
        clear_bits();
        sym_bits[1] = 1'b1;
        sym_bits[3] = 1'b1;
        send_pairs(0, 144, 4'b0011, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b0011);
        wait_outputs(144, "r54");
        check("r54 k1 A pair10", out_bit(10, 0), 1);
        check("r54 k3 A pair27", out_bit(27, 0), 1);
        check("r54 ones", ones_out(), 2);
        check_symbols(288, 3, 1, "r54");
        flush();

        // Three back-to-back 192-bit symbols
        random_bits();
        send_pairs(0, 288, 4'b1001, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b1001);
        wait_outputs(288, "stream");
        span = (out_q.size() > 0) ? out_cyc[out_cyc.size()-1] - out_cyc[0] : -1;
        check("stream start", (out_cyc.size() > 0) ? out_cyc[0] - first_in_cyc : -1, 97);
        check("stream span", span, 287);
        check_symbols(192, 2, 3, "stream");
        flush();

        // Gapped input with a mid-symbol rate change that must be ignored
        random_bits();
        send_pairs(0, 96, 4'b1001, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'b0011);
        wait_outputs(96, "gapped");
        check_symbols(192, 2, 1, "gapped");
        flush();

        // Partial symbol abandoned by a reset pulse, then a full symbol
        random_bits();
        send_pairs(0, 40, 4'b0011, 1'b0);
        @(negedge Clk);
        reset       = 1'b0;
        AB_in_valid = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        flush();
        random_bits();
        send_pairs(0, 24, 4'b0000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        wait_outputs(24, "recover");
        check_symbols(48, 1, 1, "recover");
        flush();

        check("idle outputs zero", idle_dirty, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
